pb_intc: RTL and testbench
==========================

# pb_intc

Parametrised interrupt controller for the PicoBlaze port bus. It collects up to eight peripheral interrupt lines (UART, GPIO buttons, SPI, …) into the single `interrupt` input of the `cpu` wrapper, replacing the plain OR of source lines at SoC top level. Each source has a per-source enable, edge/level mode and pending state, plus a priority-encoded vector. `data_out` is zero when not addressed, so it ORs onto `in_port` like every other `pb_*` peripheral.

## Interface
- `BASE_ADDRESS`, 8'h80: port_id window base; bits [2:0] must be 0.
- `NUM_SOURCES`, 8: number of source lines, 1..8.
- `clk`  in  1  system clock (`clk_sys`).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `port_id`  in  8  PicoBlaze port address.
- `data_in`  in  8  PicoBlaze `out_port`.
- `read_strobe`  in  1  PicoBlaze read strobe.
- `write_strobe`  in  1  PicoBlaze write strobe.
- `interrupt_ack`  in  1  PicoBlaze interrupt acknowledge.
- `irq_src`  in  NUM_SOURCES  source lines, synchronous to `clk`, active-high.
- `data_out`  out  8  read data; 8'h00 when port_id is outside the window.
- `interrupt`  out  1  request to the CPU.

## Operation
- Decode: the block is selected when `port_id[7:3] == BASE_ADDRESS[7:3]`. The register offset is `port_id[2:0]`.
- Register map:
  - 0 RAW (ro): current `irq_src`.
  - 1 ENABLE (rw).
  - 2 PENDING (ro; write-1-to-clear).
  - 3 MODE (rw): 1 = rising edge, 0 = level.
  - 4 VECTOR (ro): bit7 = valid, bits[2:0] = lowest-index source that is both pending and enabled; 8'h00 when none.
  - 5–7: read 8'h00, writes ignored.
- Register bits at positions ≥ NUM_SOURCES read 0 and ignore writes.
- Edge mode: `prev` registers `irq_src` every clock. Pending bit i sets when `irq_src[i] & ~prev[i]`. It stays set until a write-1 to PENDING.
- Level mode: pending[i] equals the registered `irq_src[i]`. W1C has no effect.
- Simultaneous edge-set and W1C on the same bit: set wins, and the bit remains 1.
- Pending latches regardless of ENABLE. Enabling a bit that is already pending raises a request.
- Writing MODE clears pending for bits switched to edge mode. `prev` is not reset by the write, so no false edge is generated.
- Request state machine:
  - IDLE → REQ when `|(pending & enable)`.
  - REQ → ACKED on `interrupt_ack`.
  - ACKED → IDLE after exactly one cycle.
  - `interrupt` = 1 only in REQ.
  - In REQ, if `pending & enable` becomes 0 before the ack, return to IDLE and withdraw the request.
- Reset (`reset_n` low, any time):
  - ENABLE = 0, MODE = 0, PENDING = 0, `prev` = 0, state IDLE.
  - `data_out` = 8'h00, `interrupt` = 0.
  - Takes effect immediately, including mid-request or mid-access.

## Timing
- Register writes occur on the clock edge where `write_strobe` is high and the block is selected. They are visible on reads from the next cycle.
- `data_out` is registered. It reflects `port_id` and register contents from the previous edge, giving 1-cycle latency. This meets KCPSM6, which holds `port_id` for two cycles and samples `in_port` at the end of the second. `read_strobe` has no side effects.
- Edge-mode latency: a source edge at cycle N sets pending at edge N+1, and `interrupt` rises at edge N+2.
- Level-mode latency is the same.
- After an ack, `interrupt` is low for at least one cycle (ACKED). If the source is still pending, it re-asserts at the following edge.

## Configuration
- `PB_INTC_VECTOR_EN`:
  - Defined: offset 4 returns the priority vector described above.
  - Undefined: the priority encoder is not built and offset 4 reads 8'h00.
  - All other behaviour is identical either way.

## Test plan
- Reset and readback: assert `reset_n`=0 mid-REQ → `interrupt`=0, all offsets read 8'h00. Write ENABLE=8'hA5 → read 8'hA5. With NUM_SOURCES=4, write ENABLE=8'hFF → read 8'h0F.
- Edge capture and W1C: MODE=8'h01, ENABLE=8'h01, pulse `irq_src[0]` for 1 cycle → PENDING=8'h01 and `interrupt`=1 two cycles after the pulse. Write 8'h01 to PENDING → PENDING=8'h00. Issue the write in the same cycle as a new edge → PENDING stays 8'h01.
- Ack handshake: level source 2 held high, ENABLE=8'h04 → `interrupt` high. `interrupt_ack` 1 cycle → `interrupt` low for exactly 1 cycle, then high again. Drop source → `interrupt` low with no ack.
- Priority vector (`PB_INTC_VECTOR_EN` defined): pending 8'h28, ENABLE=8'hFF → VECTOR=8'h83. ENABLE=8'h20 → 8'h85. ENABLE=8'h00 → 8'h00. With the macro undefined → always 8'h00.
- Bus isolation: `port_id`=8'h88 (outside window) with pending sources → `data_out`=8'h00. A write at 8'h88 leaves all registers unchanged. Offsets 5–7 read 8'h00.

Source files
------------

// File: rtl/pb_intc.sv
// PicoBlaze port-bus interrupt controller: per-source enable, edge/level mode, W1C pending, request handshake.
// Optional priority vector at offset 4 is built only when PB_INTC_VECTOR_EN is defined.
module pb_intc #(
   parameter logic [7:0]  BASE_ADDRESS = 8'h80,
   parameter int unsigned NUM_SOURCES  = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             port_id,
   input  logic [7:0]             data_in,
   input  logic                   read_strobe,
   input  logic                   write_strobe,
   input  logic                   interrupt_ack,
   input  logic [NUM_SOURCES-1:0] irq_src,
   output logic [7:0]             data_out,
   output logic                   interrupt
);

   localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKED} state_t;

   state_t     r_state;
   logic       r_irq;
   logic [7:0] r_en;
   logic [7:0] r_mode;
   logic [7:0] r_pend;
   logic [7:0] r_prev;
   logic [7:0] r_dout;

   logic [7:0] w_irq;
   logic       w_sel;
   logic [2:0] w_off;
   logic       w_wr;
   logic [7:0] w_clr;
   logic [7:0] w_set;
   logic [7:0] w_pend;
   logic [7:0] w_act;
   logic       w_any;
   logic [7:0] w_vec;
   logic [7:0] w_rdata;
   logic       w_unused;

   generate
      if (NUM_SOURCES < 8) begin : g_pad
         assign w_irq = {{(8-NUM_SOURCES){1'b0}}, irq_src};
      end else begin : g_full
         assign w_irq = irq_src[7:0];
      end
   endgenerate

   assign w_sel    = (port_id[7:3] == BASE_ADDRESS[7:3]);
   assign w_off    = port_id[2:0];
   assign w_wr     = w_sel & write_strobe;
   assign w_clr    = (w_wr && w_off == 3'd2) ? data_in : '0;
   assign w_set    = w_irq & ~r_prev;
   // Edge bits come from the sticky latch, level bits mirror the registered source.
   assign w_pend   = (r_pend & r_mode) | (r_prev & ~r_mode);
   assign w_act    = w_pend & r_en;
   assign w_any    = |w_act;
   assign w_unused = read_strobe;

`ifdef PB_INTC_VECTOR_EN
   always_comb begin
      w_vec = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (w_act[i] && !w_vec[7]) w_vec = {5'b10000, i[2:0]};
      end
   end
`else
   assign w_vec = '0;
`endif

   always_comb begin
      w_rdata = '0;
      if (w_sel) begin
         case (w_off)
            3'd0:    w_rdata = w_irq;
            3'd1:    w_rdata = r_en;
            3'd2:    w_rdata = w_pend;
            3'd3:    w_rdata = r_mode;
            3'd4:    w_rdata = w_vec;
            default: w_rdata = '0;
         endcase
      end
   end

   // Masking with the pre-write mode clears bits newly switched to edge, since level bits never hold r_pend.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en   <= '0;
         r_mode <= '0;
         r_pend <= '0;
         r_prev <= '0;
         r_dout <= '0;
      end else begin
         r_prev <= w_irq;
         r_pend <= ((r_pend & ~w_clr) | w_set) & r_mode;
         r_dout <= w_rdata;
         if (w_wr && w_off == 3'd1) r_en   <= data_in & SRC_MASK;
         if (w_wr && w_off == 3'd3) r_mode <= data_in & SRC_MASK;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_irq   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_REQ;
                  r_irq   <= 1'b1;
               end
            end
            S_REQ: begin
               if (interrupt_ack) begin
                  r_state <= S_ACKED;
                  r_irq   <= 1'b0;
               end else if (!w_any) begin
                  r_state <= S_IDLE;
                  r_irq   <= 1'b0;
               end
            end
            S_ACKED: begin
               if (w_any) begin
                  r_state <= S_REQ;
                  r_irq   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_irq   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = r_dout;
   assign interrupt = r_irq;

endmodule

// File: tb/tb_pb_intc.sv
// Directed bench for pb_intc: vector table for register access plus hand sequences for timing corners.
module tb_pb_intc;

   logic       clk;
   logic       reset_n;
   logic [7:0] port_id;
   logic [7:0] data_in;
   logic       read_strobe;
   logic       write_strobe;
   logic       interrupt_ack;
   logic [7:0] irq8;
   logic [7:0] dout8;
   logic       int8;
   logic [7:0] dout4;
   logic       int4;

   int n_checks;
   int n_fail;

   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_WR  = 2'd1;
   localparam logic [1:0] OP_RD  = 2'd2;

`ifdef PB_INTC_VECTOR_EN
   localparam logic [7:0] VEC_ALL = 8'h83;
   localparam logic [7:0] VEC_B5  = 8'h85;
`else
   localparam logic [7:0] VEC_ALL = 8'h00;
   localparam logic [7:0] VEC_B5  = 8'h00;
`endif

   typedef struct {
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] irq;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [25];

   pb_intc #(.BASE_ADDRESS(8'h80), .NUM_SOURCES(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .port_id(port_id), .data_in(data_in),
      .read_strobe(read_strobe), .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .irq_src(irq8), .data_out(dout8), .interrupt(int8)
   );

   pb_intc #(.BASE_ADDRESS(8'h80), .NUM_SOURCES(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .port_id(port_id), .data_in(data_in),
      .read_strobe(read_strobe), .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .irq_src(irq8[3:0]), .data_out(dout4), .interrupt(int4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id      = a;
      data_in      = d;
      write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
      port_id     = a;
      read_strobe = 1'b1;
      @(negedge clk);
      read_strobe = 1'b0;
      chk(nm, dout8, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n = 1'b0; port_id = 8'h00; data_in = 8'h00;
      read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0; irq8 = 8'h00;

      tbl[0]  = '{OP_WR,  8'h81, 8'hA5, 8'h00, 8'h00};
      tbl[1]  = '{OP_RD,  8'h81, 8'h00, 8'h00, 8'hA5};
      tbl[2]  = '{OP_WR,  8'h83, 8'h3C, 8'h00, 8'h00};
      tbl[3]  = '{OP_RD,  8'h83, 8'h00, 8'h00, 8'h3C};
      tbl[4]  = '{OP_RD,  8'h80, 8'h00, 8'h00, 8'h00};
      tbl[5]  = '{OP_NOP, 8'h80, 8'h00, 8'h5A, 8'h00};
      tbl[6]  = '{OP_RD,  8'h80, 8'h00, 8'h5A, 8'h5A};
      tbl[7]  = '{OP_RD,  8'h82, 8'h00, 8'h5A, 8'h5A};
      tbl[8]  = '{OP_NOP, 8'h80, 8'h00, 8'h00, 8'h00};
      tbl[9]  = '{OP_RD,  8'h82, 8'h00, 8'h00, 8'h18};
      tbl[10] = '{OP_WR,  8'h82, 8'h08, 8'h00, 8'h00};
      tbl[11] = '{OP_RD,  8'h82, 8'h00, 8'h00, 8'h10};
      tbl[12] = '{OP_RD,  8'h88, 8'h00, 8'h00, 8'h00};
      tbl[13] = '{OP_WR,  8'h88, 8'hFF, 8'h00, 8'h00};
      tbl[14] = '{OP_WR,  8'h8A, 8'hFF, 8'h00, 8'h00};
      tbl[15] = '{OP_RD,  8'h81, 8'h00, 8'h00, 8'hA5};
      tbl[16] = '{OP_RD,  8'h82, 8'h00, 8'h00, 8'h10};
      tbl[17] = '{OP_RD,  8'h83, 8'h00, 8'h00, 8'h3C};
      tbl[18] = '{OP_WR,  8'h85, 8'hFF, 8'h00, 8'h00};
      tbl[19] = '{OP_RD,  8'h85, 8'h00, 8'h00, 8'h00};
      tbl[20] = '{OP_RD,  8'h86, 8'h00, 8'h00, 8'h00};
      tbl[21] = '{OP_RD,  8'h87, 8'h00, 8'h00, 8'h00};
      tbl[22] = '{OP_RD,  8'h84, 8'h00, 8'h00, 8'h00};
      tbl[23] = '{OP_WR,  8'h81, 8'h00, 8'h00, 8'h00};
      tbl[24] = '{OP_WR,  8'h83, 8'h00, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      chk("rst_int8", {7'b0, int8}, 8'h00);
      chk("rst_dout8", dout8, 8'h00);
      chk("rst_dout4", dout4, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);

      // Register access table; no enabled source is ever pending here.
      for (int i = 0; i < 25; i++) begin
         irq8         = tbl[i].irq;
         port_id      = tbl[i].addr;
         data_in      = tbl[i].data;
         write_strobe = (tbl[i].op == OP_WR);
         read_strobe  = (tbl[i].op == OP_RD);
         @(negedge clk);
         write_strobe = 1'b0;
         read_strobe  = 1'b0;
         if (tbl[i].op == OP_RD) chk($sformatf("tbl%0d_dout", i), dout8, tbl[i].exp);
         chk($sformatf("tbl%0d_int", i), {7'b0, int8}, 8'h00);
      end

      // Edge capture, latency and W1C.
      wr(8'h83, 8'h01);
      wr(8'h81, 8'h01);
      irq8 = 8'h01;
      @(negedge clk);
      chk("edge_lat1", {7'b0, int8}, 8'h00);
      irq8 = 8'h00;
      @(negedge clk);
      chk("edge_lat2", {7'b0, int8}, 8'h01);
      rd(8'h82, 8'h01, "edge_pend");
      wr(8'h82, 8'h01);
      rd(8'h82, 8'h00, "w1c_pend");
      chk("w1c_int", {7'b0, int8}, 8'h00);
      irq8 = 8'h01;
      port_id = 8'h82; data_in = 8'h01; write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
      irq8 = 8'h00;
      rd(8'h82, 8'h01, "set_wins");
      wr(8'h82, 8'h01);
      wr(8'h81, 8'h00);
      wr(8'h83, 8'h00);
      repeat (2) @(negedge clk);
      chk("seqA_idle", {7'b0, int8}, 8'h00);

      // Level source with ack handshake, then withdrawal without ack.
      wr(8'h81, 8'h04);
      irq8 = 8'h04;
      @(negedge clk);
      chk("lvl_lat1", {7'b0, int8}, 8'h00);
      @(negedge clk);
      chk("lvl_lat2", {7'b0, int8}, 8'h01);
      interrupt_ack = 1'b1;
      @(negedge clk);
      interrupt_ack = 1'b0;
      chk("ack_low", {7'b0, int8}, 8'h00);
      @(negedge clk);
      chk("ack_reassert", {7'b0, int8}, 8'h01);
      irq8 = 8'h00;
      @(negedge clk);
      chk("drop_lat", {7'b0, int8}, 8'h01);
      @(negedge clk);
      chk("drop_withdraw", {7'b0, int8}, 8'h00);
      wr(8'h81, 8'h00);

      // Priority vector with pending 8'h28.
      wr(8'h83, 8'h28);
      irq8 = 8'h28;
      @(negedge clk);
      irq8 = 8'h00;
      @(negedge clk);
      rd(8'h82, 8'h28, "vec_pend");
      wr(8'h81, 8'hFF);
      rd(8'h84, VEC_ALL, "vec_all");
      wr(8'h81, 8'h20);
      rd(8'h84, VEC_B5, "vec_b5");
      wr(8'h81, 8'h00);
      rd(8'h84, 8'h00, "vec_none");

      // Asynchronous reset in the middle of a request.
      wr(8'h81, 8'h20);
      port_id = 8'h81;
      repeat (2) @(negedge clk);
      chk("pre_rst_int", {7'b0, int8}, 8'h01);
      chk("pre_rst_dout", dout8, 8'h20);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_int", {7'b0, int8}, 8'h00);
      chk("async_rst_dout", dout8, 8'h00);
      chk("async_rst_int4", {7'b0, int4}, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      for (int off = 0; off < 8; off++) begin
         rd(8'h80 + 8'(off), 8'h00, $sformatf("post_rst_off%0d", off));
      end
      chk("post_rst_int", {7'b0, int8}, 8'h00);

      // Bits above NUM_SOURCES read as zero.
      wr(8'h81, 8'hFF);
      port_id = 8'h81;
      @(negedge clk);
      chk("en_n4", dout4, 8'h0F);
      chk("en_n8", dout8, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
